// File: rtl/tri_and_sched.sv
// tri_and_sched: round-robin scheduler that shares one ternary AND2 slot
// among N requesters and returns tagged results through a registered port.
// Optional feature macro: TRI_AND_X_AS_ZERO_EN (DC tie supplies 0 instead of x).
module tri_and_sched #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  output logic [N-1:0]     req_ready,
  input  logic [2*N-1:0]   req_a,
  input  logic [2*N-1:0]   req_bsel,
  input  logic [2*N-1:0]   req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_data,
  output logic [IDW-1:0]   rsp_id,
  output logic [15:0]      x_count
);

  localparam logic [1:0] T_ZERO = 2'b00;
  localparam logic [1:0] T_ONE  = 2'b01;
  localparam logic [1:0] T_X    = 2'b10;

`ifdef TRI_AND_X_AS_ZERO_EN
  localparam logic [1:0] DC_TIE = T_ZERO;
`else
  localparam logic [1:0] DC_TIE = T_X;
`endif

  logic           rspValid_q, rspValid_d;
  logic [1:0]     rspData_q,  rspData_d;
  logic [IDW-1:0] rspId_q,    rspId_d;
  logic [IDW-1:0] ptr_q,      ptr_d;
  logic [15:0]    xCount_q,   xCount_d;

  logic           canAccept;
  logic           grantFound;
  logic           grant;
  logic [IDW-1:0] grantIdx;
  int             scanIdx;
  logic [1:0]     grantA;
  logic [1:0]     grantBsel;
  logic [1:0]     grantOwnB;
  logic [1:0]     opB;
  logic [1:0]     result;

  // The unused 11 code is folded onto x so the AND only ever sees 0, 1 or x.
  function automatic logic [1:0] normTri(input logic [1:0] v);
    return (v == 2'b11) ? T_X : v;
  endfunction

  // Three-valued AND: a 0 dominates, two 1s give 1, anything else is unknown.
  function automatic logic [1:0] triAnd(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] na;
    logic [1:0] nb;
    na = normTri(a);
    nb = normTri(b);
    if (na == T_ZERO || nb == T_ZERO) begin
      return T_ZERO;
    end else if (na == T_ONE && nb == T_ONE) begin
      return T_ONE;
    end else begin
      return T_X;
    end
  endfunction

  assign canAccept = !rspValid_q || rsp_ready;

  // Scan requesters starting at the round-robin pointer and pick the first
  // valid one; its operands are captured for evaluation in the same pass.
  always_comb begin
    grantFound = 1'b0;
    grantIdx   = '0;
    scanIdx    = 0;
    grantA     = T_ZERO;
    grantBsel  = 2'b00;
    grantOwnB  = T_ZERO;
    req_ready  = '0;
    for (int k = 0; k < N; k++) begin
      scanIdx = (int'(ptr_q) + k) % N;
      if (!grantFound && req_valid[scanIdx]) begin
        grantFound = 1'b1;
        grantIdx   = IDW'(scanIdx);
        grantA     = req_a[2*scanIdx +: 2];
        grantBsel  = req_bsel[2*scanIdx +: 2];
        grantOwnB  = req_b[2*scanIdx +: 2];
      end
    end
    if (!rst && canAccept && grantFound) begin
      req_ready[grantIdx] = 1'b1;
    end
  end

  assign grant = |req_ready;

  // Choose operand B from the constant ties or the requester's own value,
  // then evaluate the ternary AND for the granted requester.
  always_comb begin
    opB = T_ZERO;
    unique case (grantBsel)
      2'b00:   opB = T_ZERO;
      2'b01:   opB = T_ONE;
      2'b10:   opB = DC_TIE;
      default: opB = grantOwnB;
    endcase
    result = triAnd(grantA, opB);
  end

  // Next-state for the response register, pointer and x counter: a new
  // grant always refills the slot, otherwise a consumer handshake empties it.
  always_comb begin
    rspValid_d = rspValid_q;
    rspData_d  = rspData_q;
    rspId_d    = rspId_q;
    ptr_d      = ptr_q;
    xCount_d   = xCount_q;
    if (rspValid_q && rsp_ready && rspData_q == T_X && xCount_q != 16'hFFFF) begin
      xCount_d = xCount_q + 16'd1;
    end
    if (grant) begin
      rspValid_d = 1'b1;
      rspData_d  = result;
      rspId_d    = grantIdx;
      ptr_d      = (grantIdx == IDW'(N - 1)) ? '0 : grantIdx + IDW'(1);
    end else if (rspValid_q && rsp_ready) begin
      rspValid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending response without counting it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rspValid_q <= 1'b0;
      rspData_q  <= T_ZERO;
      rspId_q    <= '0;
      ptr_q      <= '0;
      xCount_q   <= 16'd0;
    end else begin
      rspValid_q <= rspValid_d;
      rspData_q  <= rspData_d;
      rspId_q    <= rspId_d;
      ptr_q      <= ptr_d;
      xCount_q   <= xCount_d;
    end
  end

  assign rsp_valid = rspValid_q;
  assign rsp_data  = rspData_q;
  assign rsp_id    = rspId_q;
  assign x_count   = xCount_q;

endmodule

// File: tb/tb_tri_and_sched.sv
// tb_tri_and_sched: randomized and directed bench for tri_and_sched with a
// behavioural reference model (Kleene AND as minimum over 0 < x < 1).
module tb_tri_and_sched;

  localparam int N   = 4;
  localparam int IDW = 2;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [2*N-1:0] req_a;
  logic [2*N-1:0] req_bsel;
  logic [2*N-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_data;
  logic [IDW-1:0] rsp_id;
  logic [15:0]    x_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic         mValid;
  logic [1:0]   mData;
  int           mId;
  int           mPtr;
  int           mX;
  logic [N-1:0] lastReady;

  logic [1:0] tieExp [3];
  logic [1:0] holdData;
  logic [IDW-1:0] holdId;

  tri_and_sched #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_bsel  (req_bsel),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .x_count   (x_count)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value with its expectation and tally the result
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Rank on the ordering 0 < x < 1; AND is the minimum rank
  function automatic int rankOf(input logic [1:0] v);
    if (v == 2'b00) return 0;
    if (v == 2'b01) return 2;
    return 1;
  endfunction

  function automatic logic [1:0] fromRank(input int r);
    if (r == 0) return 2'b00;
    if (r == 2) return 2'b01;
    return 2'b10;
  endfunction

  function automatic logic [1:0] modelResult(input logic [1:0] a, input logic [1:0] bsel,
                                             input logic [1:0] b);
    logic [1:0] opB;
    int ra;
    int rb;
    case (bsel)
      2'b00: opB = 2'b00;
      2'b01: opB = 2'b01;
`ifdef TRI_AND_X_AS_ZERO_EN
      2'b10: opB = 2'b00;
`else
      2'b10: opB = 2'b10;
`endif
      default: opB = b;
    endcase
    ra = rankOf(a);
    rb = rankOf(opB);
    return fromRank((ra < rb) ? ra : rb);
  endfunction

  task automatic setReq(input int i, input logic v, input logic [1:0] a,
                        input logic [1:0] bs, input logic [1:0] b);
    req_valid[i]     = v;
    req_a[2*i +: 2]  = a;
    req_bsel[2*i +: 2] = bs;
    req_b[2*i +: 2]  = b;
  endtask

  // Check all outputs against the model at the falling edge, advance the
  // model for the coming rising edge, then return just after that edge
  task automatic applyStimulus();
    logic [N-1:0] expReady;
    int expGrant;
    logic canAcc;
    @(negedge clk);
    expReady = '0;
    expGrant = -1;
    canAcc = !mValid || rsp_ready;
    if (!rst && canAcc) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (mPtr + k) % N;
        if (expGrant < 0 && req_valid[idx]) expGrant = idx;
      end
    end
    if (expGrant >= 0) expReady[expGrant] = 1'b1;
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(mValid));
    checkOutput("rsp_data",  32'(rsp_data),  32'(mData));
    checkOutput("rsp_id",    32'(rsp_id),    32'(mId));
    checkOutput("x_count",   32'(x_count),   32'(mX));
    checkOutput("req_ready", 32'(req_ready), 32'(expReady));
    if (rst) begin
      mValid = 1'b0;
      mData  = 2'b00;
      mId    = 0;
      mPtr   = 0;
      mX     = 0;
    end else begin
      if (rsp_ready && mValid && mData == 2'b10 && mX < 65535) mX++;
      if (expGrant >= 0) begin
        mValid = 1'b1;
        mData  = modelResult(req_a[2*expGrant +: 2], req_bsel[2*expGrant +: 2],
                             req_b[2*expGrant +: 2]);
        mId    = expGrant;
        mPtr   = (expGrant + 1) % N;
      end else if (rsp_ready && mValid) begin
        mValid = 1'b0;
      end
    end
    lastReady = expReady;
    @(posedge clk);
    #1;
  endtask

  // Main sequence: directed scenarios, random traffic, then saturation
  initial begin
    mValid = 1'b0; mData = 2'b00; mId = 0; mPtr = 0; mX = 0; lastReady = '0;
    tieExp[0] = 2'b00;
    tieExp[1] = 2'b01;
`ifdef TRI_AND_X_AS_ZERO_EN
    tieExp[2] = 2'b00;
`else
    tieExp[2] = 2'b10;
`endif
    rst = 1'b1; req_valid = '0; req_a = '0; req_bsel = '0; req_b = '0; rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    applyStimulus();
    checkOutput("reset_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_data",  32'(rsp_data),  32'd0);
    checkOutput("reset_id",    32'(rsp_id),    32'd0);
    checkOutput("reset_xcnt",  32'(x_count),   32'd0);
    rst = 1'b0;

    // Basic tie selection on requester 0 with a = 1
    rsp_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      logic [1:0] bs;
      bs = 2'(s);
      setReq(0, 1'b1, 2'b01, bs, 2'b00);
      applyStimulus();
      req_valid = '0;
      checkOutput("tie_valid", 32'(rsp_valid), 32'd1);
      checkOutput("tie_data",  32'(rsp_data),  32'(tieExp[s]));
      checkOutput("tie_id",    32'(rsp_id),    32'd0);
      applyStimulus();
    end

    // Round-robin with all requesters valid
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    for (int i = 0; i < N; i++) setReq(i, 1'b1, 2'b01, 2'b01, 2'b00);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      checkOutput("rr_id", 32'(rsp_id), 32'(i % N));
    end

    // Backpressure for five cycles, then release
    rsp_ready = 1'b0;
    holdData = rsp_data;
    holdId = rsp_id;
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("bp_data", 32'(rsp_data), 32'(holdData));
      checkOutput("bp_id",   32'(rsp_id),   32'(holdId));
    end
    rsp_ready = 1'b1;
    applyStimulus();
    checkOutput("bp_release_id", 32'(rsp_id), 32'd0);

    // Own operand and the 11 encoding
    req_valid = '0;
    setReq(1, 1'b1, 2'b10, 2'b11, 2'b00);
    applyStimulus();
    checkOutput("own_b_zero", 32'(rsp_data), 32'd0);
    checkOutput("own_b_id",   32'(rsp_id),   32'd1);
    setReq(1, 1'b1, 2'b11, 2'b11, 2'b01);
    applyStimulus();
    checkOutput("enc11_x", 32'(rsp_data), 32'h2);
    req_valid = '0;
    applyStimulus();

    // Random traffic that respects request stability while waiting
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && !lastReady[i])) begin
          setReq(i, 1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 2'($urandom));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 63) == 0);
      applyStimulus();
    end
    rst = 1'b0;

    // Drive x_count to saturation with a stream of x results
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    req_valid = '0;
    setReq(0, 1'b1, 2'b01, 2'b11, 2'b10);
    rsp_ready = 1'b1;
    for (int c = 0; c < 65540; c++) applyStimulus();
    checkOutput("xcnt_saturated", 32'(x_count), 32'hFFFF);
    checkOutput("xcnt_pending",   32'(rsp_valid), 32'd1);

    // Reset with a pending x response: dropped and not counted
    rst = 1'b1;
    applyStimulus();
    checkOutput("rst_mid_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_mid_xcnt",  32'(x_count),   32'd0);
    rst = 1'b0;
    req_valid = '0;
    applyStimulus();
    applyStimulus();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tri_and_sched.md
# tri_and_sched

Round-robin scheduler that shares one ternary-logic AND2 evaluation slot among `N` requesters. Each requester supplies operand A and selects operand B from a GND tie (0), a VCC tie (1), a don't-care tie (x), or its own operand. The block evaluates the three-valued AND and returns the result, tagged with the requester id, through a single registered response port. It sits between netlist-evaluation clients and the shared constant/gate resource, with ready/valid handshakes on both sides.

## Interface
- `N`, default 4: number of requesters, 2..8.
- `IDW`, default 2: response id width, equal to clog2(N).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  N  request present, one bit per requester.
- `req_ready`  out  N  grant; at most one bit high per cycle.
- `req_a`  in  2N  operand A per requester, ternary encoding.
- `req_bsel`  in  2N  operand-B source per requester: 00 GND, 01 VCC, 10 DC, 11 own `req_b`.
- `req_b`  in  2N  requester's own operand B, used only when bsel = 11.
- `rsp_valid`  out  1  response register holds a result.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_data`  out  2  ternary AND result.
- `rsp_id`  out  IDW  index of the requester that produced the result.
- `x_count`  out  16  saturating count of x results accepted by the consumer.

## Operation
- **Ternary encoding.** 00 = 0, 01 = 1, 10 = x. Input 11 is treated as x. Outputs never carry 11.
- **AND rule.**
  - Either operand 0 → 0.
  - Both operands 1 → 1.
  - Otherwise → x.
- **Acceptance condition.** `can_accept = !rsp_valid || rsp_ready`.
- **Grant.** When `can_accept` is high, the first requester with `req_valid` set gets `req_ready`. Search order is `ptr`, `ptr+1`, …, wrapping at N−1 to 0. `req_ready[i]` is combinational from `req_valid`, `ptr` and `can_accept`. It is never high without the matching `req_valid[i]`.
- **On a grant to requester g:**
  - The result and `g` load into the response register.
  - `rsp_valid` is set to 1.
  - `ptr` becomes (g+1) mod N.
- **No grant, consumer handshake.** If `rsp_ready && rsp_valid` and there is no new grant, `rsp_valid` clears.
- **Both in the same cycle.** A consumer handshake and a new grant in the same cycle leave `rsp_valid` at 1, holding the new data (full throughput).
- **Stall.** While `rsp_valid && !rsp_ready`, `rsp_data`, `rsp_id` and `ptr` hold, and every `req_ready` bit is 0.
- **x_count.** Increments by 1 on each consumer handshake whose `rsp_data` = 10. It saturates at 0xFFFF and never wraps.
- **Reset values.**
  - `rsp_valid` = 0, `rsp_data` = 00, `rsp_id` = 0.
  - `ptr` = 0, `x_count` = 0.
  - `req_ready` = 0 during the reset cycle.
- **Reset mid-operation.** A pending response is discarded and never counted.

## Timing
- **Latency.** A request accepted in cycle t appears on `rsp_valid`/`rsp_data` at cycle t+1.
- **Throughput.** One result per cycle while `rsp_ready` stays high.
- **Handshake stability.** Requesters hold `req_a`, `req_bsel` and `req_b` stable while `req_valid` is high and `req_ready` is low.
- **Fairness.** A continuously valid requester is granted within N accepting cycles.
- **x_count timing.** The increment is visible the cycle after the handshake.

## Configuration
- `TRI_AND_X_AS_ZERO_EN`
  - **Defined:** bsel = 10 (the DC tie) supplies 0 instead of x, mirroring constant-folding of don't-cares to GND. An x arriving on `req_a` or own `req_b` still follows the ternary rule.
  - **Undefined:** the DC tie supplies x.

## Test plan
- **Basic tie selection.** Reset, then requester 0 valid with a = 01:
  - bsel = 00 → `rsp_data` = 00.
  - bsel = 01 → 01.
  - bsel = 10 → 10 without the macro, 00 with it.
  - Each response has `rsp_id` = 0 and appears one cycle after the grant.
- **Round-robin.** All four requesters valid continuously with `rsp_ready` = 1. Grants go 0, 1, 2, 3, 0, … and `rsp_id` follows the same sequence one cycle later.
- **Backpressure.** Hold `rsp_ready` = 0 for 5 cycles with requests pending:
  - `req_ready` stays all-zero.
  - `rsp_data` and `rsp_id` stay stable.
  - Raising `rsp_ready` gives a handshake and a new grant in the same cycle.
- **Own operand and 11 encoding.** bsel = 11 with `req_b` = 00 and a = 10 → 00. a = 11, b = 01 → 10.
- **x_count saturation and reset.** Preload `x_count` near 0xFFFF through repeated x results:
  - It saturates at 0xFFFF.
  - Asserting `rst` with `rsp_valid` = 1 clears `rsp_valid` and `x_count` on the next edge, with no count from the dropped response.
